// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  typedef logic [1:0] state_t;

  // Sequencer states
  localparam state_t IDLE   = 2'd0;
  localparam state_t MUL    = 2'd1;
  localparam state_t DIV    = 2'd2;
  localparam state_t DIVFIX = 2'd3;

  // Bit positions inside the two-bit op fields
  localparam int SIGNED_BIT   = 1;
  localparam int UNSIGNED_BIT = 0;
  localparam int HI_BIT       = 1;
  localparam int LO_BIT       = 0;

  // Restoring-division iterations, tied to the 32-bit operand width
  localparam int DIV_ITER = 32;
  localparam int DATA_W   = 32;

endpackage

// File: rtl/muldiv_div_core.sv
// Radix-2 restoring divider datapath: one quotient bit per enabled step.
import muldiv_pkg::*;

module div_radix2_core #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done_iter,
  output logic [DATA_W-1:0] rem,
  output logic [DATA_W-1:0] quo
);

  logic [DATA_W-1:0] dvs;
  logic [31:0]       count;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   diff;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    rem_shift = {rem, quo[DATA_W-1]};
    diff      = rem_shift - {1'b0, dvs};
  end

  // Asserted while the final iteration is being performed
  assign done_iter = (count == 32'(ITER - 1));

  // Load operands on start, otherwise advance one restoring step per enable
  always_ff @(posedge clk) begin
    if (reset) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (start) begin
      rem   <= '0;
      quo   <= dividend;
      dvs   <= divisor;
      count <= '0;
    end else if (step) begin
      if (!diff[DATA_W]) begin
        rem <= diff[DATA_W-1:0];
        quo <= {quo[DATA_W-2:0], 1'b1};
      end else begin
        rem <= rem_shift[DATA_W-1:0];
        quo <= {quo[DATA_W-2:0], 1'b0};
      end
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO, with the
// pipeline stalls and the divide-done pulse.
import muldiv_pkg::*;

module muldiv_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [1:0]  mult_op,
  input  logic [1:0]  div_op,
  input  logic [1:0]  mthl_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [1:0]  mfhl_de,
  input  logic        cancel,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        issue_stall,
  output logic        mfhl_stall,
  output logic        div_done
);

  // Magnitude of a possibly signed operand
  function automatic logic [31:0] mag(input logic [31:0] v, input logic signed_op);
    return (signed_op && v[31]) ? -v : v;
  endfunction

  // Two's-complement negation when requested
  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t             state;
  logic               req_mul, req_div, req_mthl;
  logic               accept, acc_div, acc_mul, acc_mthl;
  logic               div_signed;
  logic [31:0]        op_a, op_b;
  logic               mul_signed;
  logic               sign_a, sign_b;
  logic [2:0]         mul_cnt;
  logic signed [63:0] mul_a_ext, mul_b_ext, prod;
  logic               done_iter;
  logic [31:0]        rem, quo;
  logic [31:0]        rem_fix, quo_fix;

  // Request decode with div > mult > mthl priority
  always_comb begin
    req_mul    = mult_op[SIGNED_BIT] | mult_op[UNSIGNED_BIT];
    req_div    = div_op[SIGNED_BIT] | div_op[UNSIGNED_BIT];
    req_mthl   = mthl_op[HI_BIT] | mthl_op[LO_BIT];
    div_signed = div_op[SIGNED_BIT];
    accept     = (state == IDLE) & issue_valid & ~cancel;
    acc_div    = accept & req_div;
    acc_mul    = accept & ~req_div & req_mul;
    acc_mthl   = accept & ~req_div & ~req_mul & req_mthl;
  end

  // Full 64-bit product from the latched operands
  always_comb begin
    mul_a_ext = mul_signed ? {{32{op_a[31]}}, op_a} : {32'b0, op_a};
    mul_b_ext = mul_signed ? {{32{op_b[31]}}, op_b} : {32'b0, op_b};
    prod      = mul_a_ext * mul_b_ext;
  end

  // Sign restoration: quotient sign is the XOR, remainder follows dividend
  always_comb begin
    quo_fix = cond_neg(quo, sign_a ^ sign_b);
    rem_fix = cond_neg(rem, sign_a);
  end

  div_radix2_core #(
    .DATA_W (DATA_W),
    .ITER   (DIV_ITER)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (acc_div),
    .clear     (cancel),
    .step      ((state == DIV) & ~cancel),
    .dividend  (mag(src_a, div_signed)),
    .divisor   (mag(src_b, div_signed)),
    .done_iter (done_iter),
    .rem       (rem),
    .quo       (quo)
  );

  // Sequencer state, latched operands and the architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      hi         <= '0;
      lo         <= '0;
      op_a       <= '0;
      op_b       <= '0;
      mul_signed <= 1'b0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      mul_cnt    <= '0;
    end else if (cancel) begin
      state   <= IDLE;
      mul_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_div) begin
            sign_a <= div_signed & src_a[31];
            sign_b <= div_signed & src_b[31];
            state  <= DIV;
          end else if (acc_mul) begin
            op_a       <= src_a;
            op_b       <= src_b;
            mul_signed <= mult_op[SIGNED_BIT];
            mul_cnt    <= '0;
            state      <= MUL;
          end else if (acc_mthl) begin
            if (mthl_op[HI_BIT]) hi <= src_a;
            if (mthl_op[LO_BIT]) lo <= src_a;
          end
        end
        MUL: begin
          if (mul_cnt == 3'(MUL_LAT - 1)) begin
            hi    <= prod[63:32];
            lo    <= prod[31:0];
            state <= IDLE;
          end else begin
            mul_cnt <= mul_cnt + 3'd1;
          end
        end
        DIV: begin
          if (done_iter) state <= DIVFIX;
        end
        default: begin
          hi    <= rem_fix;
          lo    <= quo_fix;
          state <= IDLE;
        end
      endcase
    end
  end

  // Status and stall outputs
  always_comb begin
    busy        = (state != IDLE);
    issue_stall = issue_valid & (req_mul | req_div | req_mthl) & (state != IDLE);
    mfhl_stall  = (|mfhl_de) & busy;
    div_done    = (state == DIVFIX) & ~cancel;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: multiply, divide, corner cases, stalls,
// cancel and mid-operation reset.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [1:0]  mult_op = 2'b00;
  logic [1:0]  div_op = 2'b00;
  logic [1:0]  mthl_op = 2'b00;
  logic [31:0] src_a = 32'h0;
  logic [31:0] src_b = 32'h0;
  logic [1:0]  mfhl_de = 2'b00;
  logic        cancel = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, issue_stall, mfhl_stall, div_done;

  int vectors = 0;
  int errs = 0;

  muldiv_ctrl #(.MUL_LAT(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .mult_op     (mult_op),
    .div_op      (div_op),
    .mthl_op     (mthl_op),
    .src_a       (src_a),
    .src_b       (src_b),
    .mfhl_de     (mfhl_de),
    .cancel      (cancel),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .issue_stall (issue_stall),
    .mfhl_stall  (mfhl_stall),
    .div_done    (div_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle starting just after edge T
  task automatic issue(input logic [1:0] m, input logic [1:0] d, input logic [1:0] t,
                       input logic [31:0] a, input logic [31:0] b);
    issue_valid = 1'b1;
    mult_op = m;
    div_op = d;
    mthl_op = t;
    src_a = a;
    src_b = b;
    tick();
    issue_valid = 1'b0;
    mult_op = 2'b00;
    div_op = 2'b00;
    mthl_op = 2'b00;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk(tag, {31'b0, busy}, 32'h0);
  endtask

  // Divide with exact latency checks on div_done and the HI/LO update
  task automatic div_run(input string tag, input logic [1:0] d, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
    issue(2'b00, d, 2'b00, a, b);
    repeat (31) tick();
    chk({tag, "_done_early"}, {31'b0, div_done}, 32'h0);
    tick();
    chk({tag, "_done"}, {31'b0, div_done}, 32'h1);
    chk({tag, "_busy_fix"}, {31'b0, busy}, 32'h1);
    tick();
    chk({tag, "_done_clr"}, {31'b0, div_done}, 32'h0);
    chk({tag, "_busy_end"}, {31'b0, busy}, 32'h0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int n;
    int bad;
    logic seen;

    // Reset state
    repeat (3) tick();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_div_done", {31'b0, div_done}, 32'h0);
    chk("rst_mfhl_stall", {31'b0, mfhl_stall}, 32'h0);
    reset = 1'b0;
    tick();
    chk("rst_issue_stall", {31'b0, issue_stall}, 32'h0);

    // MULTU 0xFFFFFFFF * 2
    issue(2'b01, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h2);
    chk("multu_busy", {31'b0, busy}, 32'h1);
    chk("multu_hi_early", hi, 32'h0);
    tick();
    chk("multu_busy_end", {31'b0, busy}, 32'h0);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    // MULT -1 * -1
    issue(2'b10, 2'b00, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    chk("mult_m1_hi", hi, 32'h0);
    chk("mult_m1_lo", lo, 32'h1);

    // MULT 0x80000000 * 2
    issue(2'b10, 2'b00, 2'b00, 32'h80000000, 32'h2);
    tick();
    chk("mult_min_hi", hi, 32'hFFFFFFFF);
    chk("mult_min_lo", lo, 32'h0);

    // Signed and unsigned division, including divide-by-zero and overflow
    div_run("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    div_run("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14);
    div_run("divu_5_0", 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    div_run("div_m8_0", 2'b10, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFF8, 32'h00000001);
    div_run("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    // Div and mult requested together: div wins
    issue(2'b01, 2'b01, 2'b00, 32'd100, 32'd7);
    tick();
    chk("prio_busy", {31'b0, busy}, 32'h1);
    wait_idle("prio_idle");
    chk("prio_hi", hi, 32'd2);
    chk("prio_lo", lo, 32'd14);

    // Stalls during DIV 100 / -7, then the held MULT is taken
    issue(2'b00, 2'b10, 2'b00, 32'd100, 32'hFFFFFFF9);
    issue_valid = 1'b1;
    mult_op = 2'b10;
    src_a = 32'h80000000;
    src_b = 32'h2;
    mfhl_de = 2'b10;
    n = 0;
    bad = 0;
    tick();
    while (busy && n < 60) begin
      if (!(issue_stall === 1'b1 && mfhl_stall === 1'b1)) bad++;
      n++;
      tick();
    end
    chk("ovl_stall_bad", 32'(bad), 32'd0);
    chk("ovl_busy_cycles", 32'(n), 32'd32);
    chk("ovl_stall_idle", {31'b0, issue_stall}, 32'h0);
    chk("ovl_mfhl_idle", {31'b0, mfhl_stall}, 32'h0);
    chk("ovl_div_hi", hi, 32'd2);
    chk("ovl_div_lo", lo, 32'hFFFFFFF2);
    tick();
    chk("ovl_mul_busy", {31'b0, busy}, 32'h1);
    issue_valid = 1'b0;
    mult_op = 2'b00;
    mfhl_de = 2'b00;
    tick();
    chk("ovl_mul_hi", hi, 32'hFFFFFFFF);
    chk("ovl_mul_lo", lo, 32'h0);

    // MTHI / MTLO preload
    issue(2'b00, 2'b00, 2'b10, 32'hAAAA0000, 32'h0);
    chk("mthi_hi", hi, 32'hAAAA0000);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    issue(2'b00, 2'b00, 2'b01, 32'h00005555, 32'h0);
    chk("mtlo_lo", lo, 32'h00005555);
    chk("mtlo_hi", hi, 32'hAAAA0000);

    // Cancel in IDLE suppresses acceptance
    cancel = 1'b1;
    issue(2'b01, 2'b00, 2'b00, 32'd3, 32'd3);
    cancel = 1'b0;
    chk("cancel_idle_busy", {31'b0, busy}, 32'h0);
    tick();
    chk("cancel_idle_lo", lo, 32'h00005555);

    // Cancel mid-divide
    issue(2'b00, 2'b10, 2'b00, 32'd100, 32'd7);
    repeat (9) tick();
    chk("cancel_busy_before", {31'b0, busy}, 32'h1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", {31'b0, busy}, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (div_done) seen = 1'b1;
    end
    chk("cancel_no_done", {31'b0, seen}, 32'h0);
    chk("cancel_hi", hi, 32'hAAAA0000);
    chk("cancel_lo", lo, 32'h00005555);

    // Divide started after cancel runs to normal completion
    div_run("post_cancel", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14);

    // Reset mid-divide
    issue(2'b00, 2'b10, 2'b00, 32'd100, 32'd7);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_hi", hi, 32'h0);
    chk("rstmid_lo", lo, 32'h0);
    chk("rstmid_busy", {31'b0, busy}, 32'h0);

    // Still functional after reset
    issue(2'b01, 2'b00, 2'b00, 32'd3, 32'd5);
    tick();
    chk("post_rst_lo", lo, 32'd15);
    chk("post_rst_hi", hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
